// File: rtl/filter_ext.sv
// Per-channel input filter: bypass, half-cycle glitch rejection, or saturating
// debounce, with registered edge pulses and a busy flag.
module filter_ext #(
    parameter int              WIDTH      = 32,
    parameter int              CNTW       = 4,
    parameter logic [1:0]      RESET_MODE = 2'b01,
    parameter logic [CNTW-1:0] RESET_THR  = 4'd3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] indata,
    input  logic [WIDTH-1:0] indata180,
    input  logic             cfg_wr,
    input  logic [1:0]       cfg_mode,
    input  logic [CNTW-1:0]  cfg_thr,
    output logic [WIDTH-1:0] outdata,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             busy
);

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_HALF     = 2'b01;
    localparam logic [1:0] MODE_DEBOUNCE = 2'b10;

    logic [1:0]       mode;
    logic [CNTW-1:0]  thr;
    logic [CNTW:0]    eff_thr;
    logic [WIDTH-1:0] dly_in;
    logic [WIDTH-1:0] dly_in180;
    logic [WIDTH-1:0] prev_out;
    logic [WIDTH-1:0] out_nxt;
    logic             busy_nxt;
    logic [CNTW-1:0]  cnt     [WIDTH];
    logic [CNTW-1:0]  cnt_nxt [WIDTH];
    logic [CNTW:0]    cnt_inc [WIDTH];

    // A threshold of zero behaves as one so a debounced toggle is always possible.
    assign eff_thr = (thr == '0) ? {{CNTW{1'b0}}, 1'b1} : {1'b0, thr};

    always_comb begin
        busy_nxt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_inc[i] = {1'b0, cnt[i]} + {{CNTW{1'b0}}, 1'b1};
            busy_nxt   = busy_nxt | (cnt[i] != '0);
        end
    end

    // cfg_wr is a single-cycle strobe with no ready: it is accepted on the edge
    // where it is high, clears every counter and holds outdata for that edge.
    always_comb begin
        out_nxt = outdata;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        if (cfg_wr) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_nxt[i] = '0;
            end
        end else begin
            case (mode)
                MODE_BYPASS: begin
                    out_nxt = indata;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_nxt[i] = '0;
                    end
                end
                MODE_HALF: begin
                    out_nxt = (outdata | dly_in | indata) & dly_in180;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_nxt[i] = '0;
                    end
                end
                MODE_DEBOUNCE: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (dly_in[i] == outdata[i]) begin
                            cnt_nxt[i] = '0;
                        end else if (cnt_inc[i] >= eff_thr) begin
                            out_nxt[i] = ~outdata[i];
                            cnt_nxt[i] = '0;
                        end else if (&cnt[i]) begin
                            cnt_nxt[i] = cnt[i];
                        end else begin
                            cnt_nxt[i] = cnt_inc[i][CNTW-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode      <= RESET_MODE;
            thr       <= RESET_THR;
            dly_in    <= '0;
            dly_in180 <= '0;
            outdata   <= '0;
            prev_out  <= '0;
            rise      <= '0;
            fall      <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            if (cfg_wr) begin
                mode <= cfg_mode;
                thr  <= cfg_thr;
            end
            dly_in    <= indata;
            dly_in180 <= indata180;
            outdata   <= out_nxt;
            prev_out  <= outdata;
            rise      <= outdata & ~prev_out;
            fall      <= ~outdata & prev_out;
            busy      <= busy_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule
